// File: rtl/store_buffer.sv
// Circular store buffer between the ALU stage and data memory.
// It merges back-to-back stores to the same word and lets loads read buffered data early.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 72
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ADDR_W-1:0]              in_addr,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           mem_stall,
   output logic                           mem_write_enable,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_data,
   input  logic [ADDR_W-1:0]              lookup_addr,
   output logic                           lookup_hit,
   output logic [DATA_W-1:0]              lookup_data,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [PTR_W-1:0]  young_idx;
   logic [PTR_W-1:0]  lk_idx;
   logic              empty, accept, retire, coalesce, alloc;

   always_comb begin
      empty            = (count_q == '0);
      in_ready         = (count_q != CNT_W'(DEPTH));
      mem_write_enable = !empty && !mem_stall;
      retire           = mem_write_enable;
      accept           = in_valid && in_ready;
      young_idx        = tail_q - PTR_W'(1);
      // A lone entry that is leaving this cycle cannot absorb the new store.
      coalesce         = accept && !empty && (addr_q[young_idx] == in_addr)
                         && !(retire && (count_q == CNT_W'(1)));
      alloc            = accept && !coalesce;
      mem_addr         = empty ? '0 : addr_q[head_q];
      mem_data         = empty ? '0 : data_q[head_q];
   end

   // Scan oldest to youngest so the last match found is the youngest one.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      lk_idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addr_q[lk_idx] == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[lk_idx];
         end
      end
   end

   always_comb begin
      head_d  = retire ? head_q + PTR_W'(1) : head_q;
      tail_d  = alloc  ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q;
      if (alloc && !retire)
         count_d = count_q + CNT_W'(1);
      else if (retire && !alloc)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is qualified by count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_q[tail_q] <= in_addr;
         data_q[tail_q] <= in_data;
      end else if (coalesce) begin
         data_q[young_idx] <= in_data;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand sequences, and randomized
// traffic compared against a queue-based reference model.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 7;
   localparam int DW    = 72;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready, mem_stall, mem_write_enable, lookup_hit;
   logic [AW-1:0] in_addr, mem_addr, lookup_addr;
   logic [DW-1:0] in_data, mem_data, lookup_data;
   logic [2:0]    count;

   int n_total = 0;
   int n_pass  = 0;

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .mem_stall(mem_stall),
      .mem_write_enable(mem_write_enable), .mem_addr(mem_addr), .mem_data(mem_data),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst; logic v; logic [AW-1:0] a; logic [DW-1:0] d; logic st; logic [AW-1:0] la;
      logic e_rdy; logic e_we; logic [AW-1:0] e_ma; logic [DW-1:0] e_md;
      logic e_hit; logic [DW-1:0] e_ld; logic [2:0] e_cnt;
   } vec_t;

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;

   vec_t tbl[$];
   ent_t mq[$];

   function automatic vec_t mk(logic rst, logic v, logic [AW-1:0] a, logic [DW-1:0] d,
                               logic st, logic [AW-1:0] la, logic rdy, logic we,
                               logic [AW-1:0] ma, logic [DW-1:0] md, logic hit,
                               logic [DW-1:0] ld, logic [2:0] cnt);
      vec_t r;
      r.rst = rst; r.v = v; r.a = a; r.d = d; r.st = st; r.la = la;
      r.e_rdy = rdy; r.e_we = we; r.e_ma = ma; r.e_md = md;
      r.e_hit = hit; r.e_ld = ld; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      else
         n_pass++;
   endtask

   task automatic check_out(input string tag, input logic rdy, input logic we,
                            input logic [AW-1:0] ma, input logic [DW-1:0] md,
                            input logic hit, input logic [DW-1:0] ld, input logic [2:0] cnt);
      chk({tag, ".in_ready"}, DW'(in_ready), DW'(rdy));
      chk({tag, ".mem_we"}, DW'(mem_write_enable), DW'(we));
      chk({tag, ".mem_addr"}, DW'(mem_addr), DW'(ma));
      chk({tag, ".mem_data"}, mem_data, md);
      chk({tag, ".lookup_hit"}, DW'(lookup_hit), DW'(hit));
      chk({tag, ".lookup_data"}, lookup_data, ld);
      chk({tag, ".count"}, DW'(count), DW'(cnt));
   endtask

   task automatic drive(input logic rst, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic st, input logic [AW-1:0] la);
      @(negedge clk);
      reset = rst; in_valid = v; in_addr = a; in_data = d; mem_stall = st; lookup_addr = la;
      #1;
   endtask

   // Reference model: one clock edge applied to the entry queue.
   task automatic model_edge(input logic rst, input logic v, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic st);
      bit acc, ret, coal;
      ent_t e;
      if (rst) begin
         mq.delete();
         return;
      end
      acc  = v && (mq.size() != DEPTH);
      ret  = (mq.size() != 0) && !st;
      coal = acc && (mq.size() != 0) && (mq[$].a == a) && !(ret && mq.size() == 1);
      if (ret) void'(mq.pop_front());
      if (acc) begin
         if (coal) mq[$].d = d;
         else begin
            e.a = a; e.d = d;
            mq.push_back(e);
         end
      end
   endtask

   task automatic mstep(input string tag, input logic rst, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic st, input logic [AW-1:0] la);
      logic hit;
      logic [DW-1:0] ld;
      bit ne;
      drive(rst, v, a, d, st, la);
      ne = (mq.size() != 0);
      hit = 1'b0; ld = '0;
      foreach (mq[i]) if (mq[i].a == la) begin hit = 1'b1; ld = mq[i].d; end
      check_out(tag, mq.size() != DEPTH, ne && !st, ne ? mq[0].a : '0, ne ? mq[0].d : '0,
                hit, ld, 3'(mq.size()));
      @(posedge clk);
      model_edge(rst, v, a, d, st);
   endtask

   initial begin
      reset = 1'b1; in_valid = 0; in_addr = 0; in_data = 0; mem_stall = 0; lookup_addr = 0;
      repeat (2) @(posedge clk);
      mq.delete();

      // basic push/write (row 0 also covers reset state)
      tbl.push_back(mk(0,1,7'h05,72'h0A,0,7'h00, 1,0,7'h00,72'h0,0,72'h0,0));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h05, 1,1,7'h05,72'h0A,1,72'h0A,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h05, 1,0,7'h00,72'h0,0,72'h0,0));
      // fill while stalled, no full-bypass, then in-order drain
      tbl.push_back(mk(0,1,7'h01,72'h11,1,7'h00, 1,0,7'h00,72'h0,0,72'h0,0));
      tbl.push_back(mk(0,1,7'h02,72'h12,1,7'h01, 1,0,7'h01,72'h11,1,72'h11,1));
      tbl.push_back(mk(0,1,7'h03,72'h13,1,7'h00, 1,0,7'h01,72'h11,0,72'h0,2));
      tbl.push_back(mk(0,1,7'h04,72'h14,1,7'h00, 1,0,7'h01,72'h11,0,72'h0,3));
      tbl.push_back(mk(0,1,7'h05,72'h15,1,7'h04, 0,0,7'h01,72'h11,1,72'h14,4));
      tbl.push_back(mk(0,1,7'h06,72'h16,0,7'h05, 0,1,7'h01,72'h11,0,72'h0,4));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h06, 1,1,7'h02,72'h12,0,72'h0,3));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h00, 1,1,7'h03,72'h13,0,72'h0,2));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h00, 1,1,7'h04,72'h14,0,72'h0,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h00, 1,0,7'h00,72'h0,0,72'h0,0));
      // coalesce into tail
      tbl.push_back(mk(0,1,7'h10,72'h01,1,7'h10, 1,0,7'h00,72'h0,0,72'h0,0));
      tbl.push_back(mk(0,1,7'h10,72'h02,1,7'h10, 1,0,7'h10,72'h01,1,72'h01,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,1,7'h10, 1,0,7'h10,72'h02,1,72'h02,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h10, 1,1,7'h10,72'h02,1,72'h02,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h10, 1,0,7'h00,72'h0,0,72'h0,0));
      // youngest-match forwarding
      tbl.push_back(mk(0,1,7'h20,72'hAA,1,7'h20, 1,0,7'h00,72'h0,0,72'h0,0));
      tbl.push_back(mk(0,1,7'h21,72'hBB,1,7'h20, 1,0,7'h20,72'hAA,1,72'hAA,1));
      tbl.push_back(mk(0,1,7'h20,72'hCC,1,7'h20, 1,0,7'h20,72'hAA,1,72'hAA,2));
      tbl.push_back(mk(0,0,7'h00,72'h00,1,7'h20, 1,0,7'h20,72'hAA,1,72'hCC,3));
      tbl.push_back(mk(0,0,7'h00,72'h00,1,7'h22, 1,0,7'h20,72'hAA,0,72'h0,3));
      // fill, then reset overrides a pending retire
      tbl.push_back(mk(0,1,7'h30,72'hDD,1,7'h30, 1,0,7'h20,72'hAA,0,72'h0,3));
      tbl.push_back(mk(0,0,7'h00,72'h00,1,7'h30, 0,0,7'h20,72'hAA,1,72'hDD,4));
      tbl.push_back(mk(1,0,7'h00,72'h00,0,7'h30, 0,1,7'h20,72'hAA,1,72'hDD,4));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h20, 1,0,7'h00,72'h0,0,72'h0,0));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h30, 1,0,7'h00,72'h0,0,72'h0,0));
      // same address as a draining single entry allocates instead of coalescing
      tbl.push_back(mk(0,1,7'h40,72'h01,0,7'h40, 1,0,7'h00,72'h0,0,72'h0,0));
      tbl.push_back(mk(0,1,7'h40,72'h02,0,7'h40, 1,1,7'h40,72'h01,1,72'h01,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h40, 1,1,7'h40,72'h02,1,72'h02,1));
      tbl.push_back(mk(0,0,7'h00,72'h00,0,7'h40, 1,0,7'h00,72'h0,0,72'h0,0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].la);
         check_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_ma, tbl[i].e_md,
                   tbl[i].e_hit, tbl[i].e_ld, tbl[i].e_cnt);
         @(posedge clk);
         model_edge(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st);
      end

      // steady stream with pointer wrap
      for (int i = 0; i < 12; i++)
         mstep($sformatf("stream%0d", i), 0, 1, AW'(i*3 + 1), DW'(100 + i), 0, AW'(i*3 - 2));
      mstep("stream_end", 0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic [DW-1:0] rd;
         rd = {$urandom, $urandom, $urandom};
         mstep($sformatf("rnd%0d", i), $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
               AW'($urandom_range(0, 7)), rd, $urandom_range(0, 9) < 4, AW'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
